instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of prefetch queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  64  byte address of the requested word.
REQ-007 SHALL have port imem_gnt  input  1  memory accepts request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid, one cycle or more after grant.
REQ-009 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-010 SHALL have port redirect  input  1  taken branch/jump from downstream CPU.
REQ-011 SHALL have port redirect_pc  input  64  branch target address.
REQ-012 SHALL have port out_valid  output  1  queue head holds a valid instruction.
REQ-013 SHALL have port out_ready  input  1  CPU consumes head this cycle.
REQ-014 SHALL have port out_instr  output  32  head instruction word.
REQ-015 SHALL have port out_pc  output  64  address of head instruction.

Function
REQ-016 SHALL keep a fetch PC register, a circular queue of DEPTH {pc,instr} entries, a count 0..DEPTH, and a 3-state FSM: RUN (nothing outstanding), WAIT (one request outstanding), DROP (one outstanding response to be discarded).
REQ-017 SHALL allow at most one outstanding memory request.
REQ-018 SHALL drive imem_req=1 in RUN when count<DEPTH and redirect=0; imem_addr=fetch PC; low otherwise except REQ-021.
REQ-019 SHALL, on imem_req&imem_gnt, latch the issued PC as pending PC, advance fetch PC by 4 (wrap mod 2^64), go RUN->WAIT.
REQ-020 SHALL, in WAIT on imem_rvalid, push {pending PC, imem_rdata} to the tail; space is guaranteed by REQ-018.
REQ-021 SHALL, in WAIT on imem_rvalid with redirect=0 and (count+1-pop)<DEPTH, assert imem_req the same cycle (back-to-back); grant keeps WAIT, no grant goes RUN.
REQ-022 SHALL pop the head when out_valid&out_ready; out_valid=(count!=0); out_instr/out_pc show the head entry.
REQ-023 SHALL support push and pop in the same cycle with count unchanged.
REQ-024 SHALL, on redirect=1: empty the queue (count=0, pointers reset), load fetch PC with {redirect_pc[63:2],2'b00}, ignore out_ready, issue no request that cycle.
REQ-025 SHALL, on redirect in WAIT without imem_rvalid, go to DROP; with imem_rvalid the same cycle, discard the data and go RUN.
REQ-026 SHALL, in DROP, discard the next imem_rvalid data and go RUN; a further redirect in DROP updates fetch PC and stays DROP.
REQ-027 SHALL ignore imem_rvalid in RUN.
REQ-028 SHALL ignore imem_gnt when imem_req=0.

Reset
REQ-029 SHALL on reset asynchronously set: fetch PC=RESET_PC, FSM=RUN, count=0, pointers=0, out_valid=0, imem_req=0, out_instr=0, out_pc=0.
REQ-030 SHALL treat reset mid-transaction as abandoning it; a response arriving after reset deasserts in RUN is ignored per REQ-027.
REQ-031 SHALL issue the first request (imem_addr=RESET_PC) in the first cycle after reset deasserts.

Verification
REQ-032 Streaming: memory grants always, rvalid one cycle later, out_ready=1 -> out_pc 0,4,8,12... one instruction per cycle after 2-cycle startup.
REQ-033 Backpressure: out_ready=0 -> exactly 4 entries (pc 0..12) queued, imem_req low; out_ready=1 -> order preserved, fetch resumes at 16.
REQ-034 Redirect in WAIT: redirect_pc=0x100 while response for 0x8 pending -> 0x8 data dropped, next out_pc=0x100.
REQ-035 Redirect coincident with rvalid and out_ready with queue holding 3 entries -> queue empty, no pop, next request addr=0x100.
REQ-036 Unaligned redirect_pc=0x203 -> imem_addr=0x200.
REQ-037 Async reset asserted with 2 entries queued and request outstanding -> out_valid=0 immediately; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Brief    : Instruction prefetcher. Issues one outstanding fetch at a time,
//            buffers returned words with their PCs in a circular queue, and
//            flushes on redirect, discarding any stale in-flight response.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [63:0]    r_pc;
    logic [63:0]    r_pend_pc;
    logic [63:0]    r_q_pc    [DEPTH];
    logic [31:0]    r_q_instr [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    logic           w_req;
    logic           w_fire;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic [CW:0]    w_cnt_after;
    logic           w_unused;

    assign w_unused    = &{1'b0, redirect_pc[1:0]};
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    // A redirect freezes the consumer side so the flush wins cleanly.
    assign w_pop       = ~w_empty & out_ready & ~redirect;
    assign w_push      = (r_state == S_WAIT) & imem_rvalid & ~redirect;
    // Occupancy once the arriving word lands; decides back-to-back issue.
    assign w_cnt_after = {1'b0, r_count} + (CW+1)'(1) - (CW+1)'(w_pop);

    assign imem_req    = w_req & ~reset;
    assign imem_addr   = r_pc;
    assign w_fire      = imem_req & imem_gnt;

    assign out_valid   = ~w_empty;
    assign out_instr   = w_empty ? 32'h0 : r_q_instr[r_rptr];
    assign out_pc      = w_empty ? 64'h0 : r_q_pc[r_rptr];

    // Next-state and request generation for the single-outstanding protocol.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_RUN: begin
                w_req = ~w_full & ~redirect;
                if (w_req && imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_state_nxt = imem_rvalid ? S_RUN : S_DROP;
                end else if (imem_rvalid) begin
                    w_req       = (w_cnt_after < (CW+1)'(DEPTH));
                    w_state_nxt = (w_req && imem_gnt) ? S_WAIT : S_RUN;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC advances on each accepted request; redirect realigns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_pend_pc <= 64'h0;
        end else begin
            if (redirect) begin
                r_pc <= {redirect_pc[63:2], 2'b00};
            end else if (w_fire) begin
                r_pc <= r_pc + 64'd4;
            end
            if (w_fire) begin
                r_pend_pc <= r_pc;
            end
        end
    end

    // Queue pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage; contents are only visible through count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wptr]    <= r_pend_pc;
            r_q_instr[r_wptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Brief    : Scoreboard bench for instr_fetch_queue with a latency-configurable
//            memory responder and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb_pc [$];

    // Stimulus intent for the next cycle, applied at the falling edge.
    logic        v_rst = 1'b1, v_ready = 1'b0, v_redir = 1'b0, v_gnt = 1'b0;
    logic [63:0] v_rpc = 64'h0;

    // Memory responder state: one slot, response m_lat cycles after grant.
    int          m_lat = 1;
    int          m_cnt = 0;
    bit          m_out = 1'b0;
    logic [63:0] m_addr = 64'h0;
    bit          gnt_flag = 1'b0;
    logic [63:0] last_gnt_addr = 64'h0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        return {16'hC0DE, lo};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        reset       = v_rst;
        out_ready   = v_ready;
        redirect    = v_redir;
        redirect_pc = v_rpc;
        imem_gnt    = v_gnt;
        if (m_out && m_cnt == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m_addr);
            m_out       = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            if (m_out) m_cnt--;
        end
        #1;
        gnt_flag = 1'b0;
        if (imem_req && imem_gnt) begin
            m_out         = 1'b1;
            m_cnt         = m_lat;
            m_addr        = imem_addr;
            gnt_flag      = 1'b1;
            last_gnt_addr = imem_addr;
        end
    endtask

    task automatic do_reset();
        v_rst   = 1'b1;
        reset   = 1'b1;
        v_redir = 1'b0;
        m_out   = 1'b0;
        sb_pc.delete();
        step();
        step();
        chk("rst_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_req",   {63'h0, imem_req},  64'h0);
        chk("rst_pc",    out_pc,             64'h0);
        chk("rst_instr", {32'h0, out_instr}, 64'h0);
        v_rst = 1'b0;
    endtask

    task automatic wait_gnt(input string name, input logic [63:0] a);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (gnt_flag && last_gnt_addr == a) found = 1'b1;
        end
        chk(name, {63'h0, found}, 64'h1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && sb_pc.size() != 0; k++) step();
        step();
        step();
        chk({name, "_sb_empty"}, 64'(sb_pc.size()), 64'h0);
        chk({name, "_idle"},     {63'h0, out_valid}, 64'h0);
    endtask

    // Monitor: every real pop is matched against the scoreboard head.
    always begin
        @(negedge clk);
        #2;
        if (!reset && out_valid && out_ready && !redirect) begin
            if (sb_pc.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got pc %h expected no output", out_pc);
            end else begin
                logic [63:0] e;
                e = sb_pc.pop_front();
                chk("pop_pc", out_pc, e);
                chk("pop_instr", {32'h0, out_instr}, {32'h0, mem_word(e)});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming: 8 grants, then one word per cycle from cycle 2.
        v_ready = 1'b1; v_gnt = 1'b1; m_lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) sb_pc.push_back(64'(4 * i));
        for (int i = 0; i < 10; i++) begin
            v_gnt = (i < 8);
            step();
            if (i == 0) begin
                chk("first_req",  {63'h0, imem_req}, 64'h1);
                chk("first_addr", imem_addr, 64'h0);
            end
            if (i >= 2) begin
                chk("stream_valid", {63'h0, out_valid}, 64'h1);
                chk("stream_pc", out_pc, 64'(4 * (i - 2)));
            end
        end
        drain("stream");

        // Backpressure: queue fills to 4 entries and fetch stops.
        v_ready = 1'b0; v_gnt = 1'b1; m_lat = 1;
        do_reset();
        repeat (10) step();
        chk("bp_req_low", {63'h0, imem_req},  64'h0);
        chk("bp_valid",   {63'h0, out_valid}, 64'h1);
        chk("bp_head",    out_pc,             64'h0);
        sb_pc.push_back(64'h0); sb_pc.push_back(64'h4);
        sb_pc.push_back(64'h8); sb_pc.push_back(64'hC);
        v_ready = 1'b1; v_gnt = 1'b0;
        drain("bp");
        chk("bp_resume_req",  {63'h0, imem_req}, 64'h1);
        chk("bp_resume_addr", imem_addr, 64'h10);

        // Redirect while the response for 0x8 is outstanding.
        v_ready = 1'b0; v_gnt = 1'b1; m_lat = 2;
        do_reset();
        wait_gnt("wait_gnt8", 64'h8);
        v_redir = 1'b1; v_rpc = 64'h100;
        step();
        chk("redir_noreq", {63'h0, imem_req}, 64'h0);
        v_redir = 1'b0;
        wait_gnt("gnt_100", 64'h100);
        v_gnt = 1'b0;
        sb_pc.push_back(64'h100);
        v_ready = 1'b1;
        drain("drop");

        // Redirect coincident with rvalid and out_ready, 3 entries queued.
        v_ready = 1'b0; v_gnt = 1'b1; m_lat = 1;
        do_reset();
        wait_gnt("wait_gnt12", 64'hC);
        v_redir = 1'b1; v_rpc = 64'h100; v_ready = 1'b1;
        step();
        chk("coinc_rvalid", {63'h0, imem_rvalid}, 64'h1);
        chk("coinc_noreq",  {63'h0, imem_req},    64'h0);
        v_redir = 1'b0;
        step();
        chk("coinc_empty", {63'h0, out_valid}, 64'h0);
        chk("coinc_req",   {63'h0, imem_req},  64'h1);
        chk("coinc_addr",  imem_addr, 64'h100);
        v_gnt = 1'b0;
        sb_pc.push_back(64'h100);
        drain("coinc");

        // Unaligned redirect target is word-aligned.
        v_redir = 1'b1; v_rpc = 64'h203;
        step();
        v_redir = 1'b0;
        step();
        chk("align_req",  {63'h0, imem_req}, 64'h1);
        chk("align_addr", imem_addr, 64'h200);

        // Async reset with 2 entries queued and a request outstanding.
        v_ready = 1'b0; v_gnt = 1'b1; m_lat = 3;
        do_reset();
        wait_gnt("wait_gnt8b", 64'h8);
        step();
        chk("ar_pre_valid", {63'h0, out_valid}, 64'h1);
        #2;
        reset = 1'b1; v_rst = 1'b1;
        #1;
        chk("ar_valid", {63'h0, out_valid}, 64'h0);
        chk("ar_req",   {63'h0, imem_req},  64'h0);
        chk("ar_pc",    out_pc,             64'h0);
        sb_pc.delete();
        v_gnt = 1'b0;
        step();
        v_rst = 1'b0;
        step();
        chk("ar_stale_rvalid", {63'h0, imem_rvalid}, 64'h1);
        chk("ar_first_req",    {63'h0, imem_req},    64'h1);
        chk("ar_first_addr",   imem_addr,            64'h0);
        v_gnt = 1'b1; m_lat = 1;
        step();
        v_gnt = 1'b0;
        sb_pc.push_back(64'h0);
        v_ready = 1'b1;
        drain("ar");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
